// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a per-register busy scoreboard and a post-reset clear sweep.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic                    flush,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic                    ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state;
  logic [AW-1:0]    sweep_idx;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [WIDTH-1:0] regs [DEPTH];

  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;

  // Sweep controller: ready is registered and goes high in the first RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR;
      sweep_idx <= AW'(1);
      ready     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (sweep_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + AW'(1);
          end
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  // Single write port into the array, shared by the sweep and write-back.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_addr;
    mem_data = wr_data;
    if (rst) begin
      if (state == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = sweep_idx;
        mem_data = '0;
      end else if (wr_en && (wr_addr != '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      regs[mem_addr] <= mem_data;
    end
  end

  // A new producer outranks a flush, which outranks the write-back clear.
  always_comb begin
    busy_next = busy;
    if (ready) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (iss_en && (iss_addr == AW'(r))) begin
          busy_next[r] = 1'b1;
        end else if (flush) begin
          busy_next[r] = 1'b0;
        end else if (wr_en && (wr_addr == AW'(r))) begin
          busy_next[r] = 1'b0;
        end
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (ready && (rd_addr[k*AW +: AW] != '0)) begin
        rd_data[k*WIDTH +: WIDTH] = regs[rd_addr[k*AW +: AW]];
        rd_busy[k]                = busy[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
          rd_data[k*WIDTH +: WIDTH] = wr_data;
          rd_busy[k]                = iss_en && (iss_addr == rd_addr[k*AW +: AW]);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed steps plus random traffic against an array/counter reference model.
module tb_regfile_scoreboard;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = $clog2(DEPTH);

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    wr_en = 1'b0;
  logic [AW-1:0]           wr_addr = '0;
  logic [WIDTH-1:0]        wr_data = '0;
  logic                    iss_en = 1'b0;
  logic [AW-1:0]           iss_addr = '0;
  logic                    flush = 1'b0;
  logic [NUM_RD*AW-1:0]    rd_addr = '0;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    ready;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural contents, busy flags, cycles left until ready.
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_busy [DEPTH];
  bit               m_ready;
  int               m_left;

  regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] port_addr(input int k);
    logic [NUM_RD*AW-1:0] v;
    v = rd_addr;
    return v[k*AW +: AW];
  endfunction

  function automatic logic [WIDTH-1:0] exp_data(input int k);
    logic [AW-1:0] a;
    a = port_addr(k);
    if (!m_ready || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int k);
    logic [AW-1:0] a;
    a = port_addr(k);
    if (!m_ready || a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return iss_en && (iss_addr == a);
`endif
    return m_busy[a];
  endfunction

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic check_outputs();
    chk("ready", WIDTH'(ready), WIDTH'(m_ready));
    for (int k = 0; k < NUM_RD; k++) begin
      chk($sformatf("rd_data%0d", k), rd_data[k*WIDTH +: WIDTH], exp_data(k));
      chk($sformatf("rd_busy%0d", k), WIDTH'(rd_busy[k]), WIDTH'(exp_busy(k)));
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      m_ready = 1'b0;
      m_left  = DEPTH - 1;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      if (flush) foreach (m_busy[i]) m_busy[i] = 1'b0;
      if (wr_en && wr_addr != '0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  // Check outputs against the model for the current inputs, then clock once.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0; rst = 1'b1;
  endtask

  initial begin
    int zeros;

    // Reset sweep with stray strobes that must leave no trace.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    model_update();
    #1;
    chk("rst_ready", WIDTH'(ready), '0);
    chk("rst_data", rd_data[WIDTH-1:0], '0);
    rst = 1'b1;
    zeros = 0;
    while (ready !== 1'b1 && zeros < 100) begin
      wr_en = (zeros < 10); wr_addr = 5; wr_data = 32'hFFFF_FFFF;
      iss_en = (zeros < 10); iss_addr = 6; flush = 1'b0;
      if (zeros < 10) zeros++; else zeros++;
      tick();
    end
    chk("sweep_len", WIDTH'(zeros), WIDTH'(DEPTH - 1));
    idle();
    set_rd(0, 5); set_rd(1, 6);
    #1;
    chk("sweep_x5", rd_data[0 +: WIDTH], '0);
    chk("sweep_x6_busy", WIDTH'(rd_busy[1]), '0);
    tick();

    // Basic write/read, including ignored write to x0.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; tick();
    wr_addr = 0; wr_data = 32'h1234_5678; tick();
    idle(); set_rd(0, 5); set_rd(1, 0);
    #1;
    chk("wr_x5", rd_data[0 +: WIDTH], 32'hDEAD_BEEF);
    chk("wr_x0", rd_data[WIDTH +: WIDTH], '0);
    tick();

    // Issue then write-back of x7.
    set_rd(0, 7); set_rd(1, 7);
    iss_en = 1'b1; iss_addr = 7; tick();
    idle(); #1; chk("iss_x7", WIDTH'(rd_busy[0]), 1);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5; tick();
    idle(); #1;
    chk("wb_x7_busy", WIDTH'(rd_busy[0]), 0);
    chk("wb_x7_data", rd_data[0 +: WIDTH], 32'hA5);

    // Same-cycle issue and write-back while busy: issue wins.
    iss_en = 1'b1; iss_addr = 7; tick();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h77; tick();
    idle(); #1;
    chk("iss_wb_busy", WIDTH'(rd_busy[1]), 1);
    chk("iss_wb_data", rd_data[WIDTH +: WIDTH], 32'h77);

    // Flush together with a fresh issue.
    iss_en = 1'b1;
    iss_addr = 3; tick();
    iss_addr = 4; tick();
    iss_addr = 9; tick();
    flush = 1'b1; iss_addr = 4; tick();
    idle(); set_rd(0, 3); set_rd(1, 4); #1;
    chk("flush_x3", WIDTH'(rd_busy[0]), 0);
    chk("flush_x4", WIDTH'(rd_busy[1]), 1);
    tick();
    set_rd(0, 9); #1;
    chk("flush_x9", WIDTH'(rd_busy[0]), 0);
    tick();

    // Same-cycle write and read of x10 (previously zero).
    set_rd(0, 10); set_rd(1, 10);
    wr_en = 1'b1; wr_addr = 10; wr_data = 32'h55AA_55AA;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd_data[WIDTH +: WIDTH], 32'h55AA_55AA);
`else
    chk("byp_same", rd_data[WIDTH +: WIDTH], '0);
`endif
    tick();
    idle(); #1;
    chk("byp_next", rd_data[0 +: WIDTH], 32'h55AA_55AA);
    tick();

    // Random traffic, occasionally including reset pulses.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 149) != 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = $urandom;
      iss_en   = $urandom_range(0, 1);
      iss_addr = AW'($urandom_range(0, DEPTH - 1));
      flush    = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NUM_RD; k++) begin
        if ($urandom_range(0, 3) == 0) set_rd(k, int'(wr_addr));
        else set_rd(k, $urandom_range(0, DEPTH - 1));
      end
      tick();
    end
    idle();
    zeros = 0;
    while (ready !== 1'b1 && zeros < 100) begin zeros++; tick(); end
    chk("rand_recover", WIDTH'(ready), 1);

    // Mid-run reset with x2 written and busy.
    wr_en = 1'b1; wr_addr = 2; wr_data = 32'h1; tick();
    idle(); iss_en = 1'b1; iss_addr = 2; tick();
    idle(); set_rd(0, 2); set_rd(1, 2); #1;
    chk("mid_pre_busy", WIDTH'(rd_busy[0]), 1);
    rst = 1'b0; tick();
    rst = 1'b1; #1;
    chk("mid_ready", WIDTH'(ready), 0);
    chk("mid_busy", WIDTH'(rd_busy[0]), 0);
    zeros = 0;
    while (ready !== 1'b1 && zeros < 100) begin zeros++; tick(); end
    chk("mid_sweep_len", WIDTH'(zeros), WIDTH'(DEPTH - 1));
    #1;
    chk("mid_x2_data", rd_data[0 +: WIDTH], '0);
    chk("mid_x2_busy", WIDTH'(rd_busy[1]), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
